// File: rtl/ece564_pkg.sv
// Shared constants and the loader state type for the input SRAM loader.
package ece564_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 12;
   localparam logic [DATA_W-1:0] END_WORD = 16'h00FF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_TERM    = 3'd2,
      ST_RUN     = 3'd3,
      ST_WAIT_HI = 3'd4,
      ST_WAIT_LO = 3'd5,
      ST_DONE    = 3'd6
   } loader_state_t;

endpackage

// File: rtl/input_sram_loader_busy_watchdog.sv
// busy_watchdog: counts enabled cycles and flags expiry in the cycle that
// would be the TIMEOUT_CYCLES-th enabled cycle. Only instantiated when the
// loader is built with LOADER_TIMEOUT_EN.
module busy_watchdog #(
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic clk,
   input  logic reset_b,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_reg;

   // Expiry is combinational so the FSM can leave the wait state on that same edge.
   assign expired = enable && (count_reg == CNT_LAST);

   // Cycle counter: cleared outside the wait window, frozen once expired.
   always_ff @(posedge clk) begin
      if (reset_b || clear) begin
         count_reg <= '0;
      end else if (enable && !expired) begin
         count_reg <= count_reg + 1'b1;
      end
   end

endmodule

// File: rtl/input_sram_loader.sv
// input_sram_loader: streams host words into the input SRAM, appends a
// terminator word, kicks the DUT and waits for its busy flag to cycle.
// Optional watchdog on the busy wait is enabled by defining LOADER_TIMEOUT_EN.
// Note: reset_b is an active-high synchronous reset despite its name.
module input_sram_loader #(
   parameter logic [ece564_pkg::DATA_W-1:0] END_WORD = ece564_pkg::END_WORD,
   parameter int ADDR_W         = ece564_pkg::ADDR_W,
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic                          clk,
   input  logic                          reset_b,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [ece564_pkg::DATA_W-1:0] s_data,
   input  logic                          s_last,
   output logic [ADDR_W-1:0]             ldr_sram_write_address,
   output logic [ece564_pkg::DATA_W-1:0] ldr_sram_write_data,
   output logic                          ldr_sram_write_enable,
   output logic                          dut_run,
   input  logic                          dut_busy,
   output logic                          job_done,
   output logic                          err_overflow,
   output logic                          err_end_word,
   output logic                          err_timeout,
   output logic [ADDR_W-1:0]             word_count
);

   import ece564_pkg::*;

   // The top address is kept free so the terminator always fits.
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   loader_state_t state_reg, state_next;

   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [ADDR_W-1:0] count_reg, count_next;
   logic [ADDR_W-1:0] base_addr, base_count;
   logic              err_overflow_reg, err_overflow_next;
   logic              err_end_word_reg, err_end_word_next;
   logic              base_overflow, base_end_word;

   logic accepting, handshake, job_start;
   logic is_end_word, at_limit, word_write;
   logic in_wait, wd_expired;

   assign accepting   = (state_reg == ST_IDLE) || (state_reg == ST_LOAD);
   assign handshake   = s_valid && accepting;
   assign job_start   = handshake && (state_reg == ST_IDLE);
   assign in_wait     = (state_reg == ST_WAIT_HI) || (state_reg == ST_WAIT_LO);

   // A new job restarts address, count and sticky errors before its first word.
   assign base_addr     = job_start ? '0 : addr_reg;
   assign base_count    = job_start ? '0 : count_reg;
   assign base_overflow = job_start ? 1'b0 : err_overflow_reg;
   assign base_end_word = job_start ? 1'b0 : err_end_word_reg;

   assign is_end_word = (s_data == END_WORD);
   assign at_limit    = (base_addr == ADDR_LAST);
   assign word_write  = handshake && !is_end_word && !at_limit;

`ifdef LOADER_TIMEOUT_EN
   logic err_timeout_reg;

   busy_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset_b (reset_b),
      .enable  (in_wait),
      .clear   (!in_wait),
      .expired (wd_expired)
   );

   // Sticky timeout flag, cleared with the other errors on a new job.
   always_ff @(posedge clk) begin
      if (reset_b) begin
         err_timeout_reg <= 1'b0;
      end else if (job_start) begin
         err_timeout_reg <= 1'b0;
      end else if (wd_expired) begin
         err_timeout_reg <= 1'b1;
      end
   end

   assign err_timeout = err_timeout_reg;
`else
   assign wd_expired  = 1'b0;
   assign err_timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset_b) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (handshake) state_next = s_last ? ST_TERM : ST_LOAD;
         end
         ST_LOAD: begin
            if (handshake && s_last) state_next = ST_TERM;
         end
         ST_TERM:    state_next = ST_RUN;
         ST_RUN:     state_next = ST_WAIT_HI;
         ST_WAIT_HI: begin
            if (wd_expired)    state_next = ST_DONE;
            else if (dut_busy) state_next = ST_WAIT_LO;
         end
         ST_WAIT_LO: begin
            if (wd_expired || !dut_busy) state_next = ST_DONE;
         end
         ST_DONE:    state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Outputs; pulses and write strobe are masked while reset is asserted.
   always_comb begin
      s_ready                = accepting || reset_b;
      ldr_sram_write_enable  = !reset_b && (word_write || (state_reg == ST_TERM));
      ldr_sram_write_address = base_addr;
      ldr_sram_write_data    = '0;
      if (state_reg == ST_TERM) begin
         ldr_sram_write_data = END_WORD;
      end else if (word_write) begin
         ldr_sram_write_data = s_data;
      end
      dut_run      = !reset_b && (state_reg == ST_RUN);
      job_done     = !reset_b && (state_reg == ST_DONE);
      err_overflow = err_overflow_reg;
      err_end_word = err_end_word_reg;
      word_count   = count_reg;
   end

   // Datapath next values: address, accepted-word count and sticky errors.
   always_comb begin
      addr_next         = base_addr;
      count_next        = base_count;
      err_overflow_next = base_overflow;
      err_end_word_next = base_end_word;
      if (handshake) begin
         count_next = base_count + 1'b1;
         if (is_end_word) begin
            err_end_word_next = 1'b1;
         end else if (at_limit) begin
            err_overflow_next = 1'b1;
         end else begin
            addr_next = base_addr + 1'b1;
         end
      end
      // Leave the next job a clean address; the count stays visible until then.
      if (state_reg == ST_DONE) begin
         addr_next = '0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset_b) begin
         addr_reg         <= '0;
         count_reg        <= '0;
         err_overflow_reg <= 1'b0;
         err_end_word_reg <= 1'b0;
      end else begin
         addr_reg         <= addr_next;
         count_reg        <= count_next;
         err_overflow_reg <= err_overflow_next;
         err_end_word_reg <= err_end_word_next;
      end
   end

endmodule

// File: tb/tb_input_sram_loader.sv
// Self-checking bench for input_sram_loader: directed and randomized jobs
// compared against a list-level model of what the SRAM should receive.
module tb_input_sram_loader;

   localparam int          AW   = 12;
   localparam int          MAXA = (1 << AW) - 1;
   localparam logic [15:0] EW   = 16'h00FF;

   logic          clk = 1'b0;
   logic          reset_b;
   logic          s_valid;
   logic          s_ready;
   logic [15:0]   s_data;
   logic          s_last;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic          wr_en;
   logic          dut_run;
   logic          dut_busy;
   logic          job_done;
   logic          err_overflow;
   logic          err_end_word;
   logic          err_timeout;
   logic [AW-1:0] word_count;

   input_sram_loader dut (
      .clk                    (clk),
      .reset_b                (reset_b),
      .s_valid                (s_valid),
      .s_ready                (s_ready),
      .s_data                 (s_data),
      .s_last                 (s_last),
      .ldr_sram_write_address (wr_addr),
      .ldr_sram_write_data    (wr_data),
      .ldr_sram_write_enable  (wr_en),
      .dut_run                (dut_run),
      .dut_busy               (dut_busy),
      .job_done               (job_done),
      .err_overflow           (err_overflow),
      .err_end_word           (err_end_word),
      .err_timeout            (err_timeout),
      .word_count             (word_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: record SRAM writes and pulses mid-cycle.
   int   mon_addr_q[$];
   int   mon_data_q[$];
   int   mon_cyc_q[$];
   int   run_count = 0, run_cyc = 0;
   int   done_count = 0, done_cyc = 0;
   int   fall_cyc = 0;
   logic prev_busy = 1'b0;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         mon_addr_q.push_back(int'(wr_addr));
         mon_data_q.push_back(int'(wr_data));
         mon_cyc_q.push_back(cyc);
      end
      if (dut_run === 1'b1) begin
         run_count++;
         run_cyc = cyc;
      end
      if (job_done === 1'b1) begin
         done_count++;
         done_cyc = cyc;
      end
      if (prev_busy && !dut_busy) fall_cyc = cyc;
      prev_busy = dut_busy;
   end

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Current job and the model's expectation for it.
   logic [15:0] job_q[$];
   int          exp_addr_q[$];
   int          exp_data_q[$];
   logic        exp_end, exp_ovf;
   int          exp_cnt;

   // Expected SRAM image from the job list: END_WORD entries vanish, words
   // beyond the last free address vanish, terminator follows the kept words.
   task automatic build_model();
      int next_addr;
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_end   = 1'b0;
      exp_ovf   = 1'b0;
      next_addr = 0;
      foreach (job_q[i]) begin
         if (job_q[i] == EW) begin
            exp_end = 1'b1;
         end else if (next_addr == MAXA) begin
            exp_ovf = 1'b1;
         end else begin
            exp_addr_q.push_back(next_addr);
            exp_data_q.push_back(int'(job_q[i]));
            next_addr++;
         end
      end
      exp_addr_q.push_back(next_addr);
      exp_data_q.push_back(int'(EW));
      exp_cnt = job_q.size() % (1 << AW);   // word_count is AW bits wide
   endtask

   // Stream job_q with occasional idle gaps on s_valid.
   task automatic send_job();
      bit hs;
      int guard;
      for (int i = 0; i < job_q.size(); i++) begin
         if ($urandom_range(3) == 0) begin
            s_valid = 1'b0;
            repeat ($urandom_range(2, 1)) step();
         end
         s_valid = 1'b1;
         s_data  = job_q[i];
         s_last  = (i == job_q.size() - 1);
         hs      = 1'b0;
         guard   = 0;
         while (!hs && guard < 50) begin
            @(negedge clk);
            hs = s_ready;
            step();
            guard++;
         end
         if (!hs) check("handshake_wait", 32'd0, 32'd1);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
   endtask

   task automatic wait_run(input int r0);
      int guard = 0;
      while (run_count == r0 && guard < 100) begin
         step();
         guard++;
      end
   endtask

   // Full job: stream, answer dut_run with a busy pulse, then check everything.
   task automatic run_job(input int bdelay, input int blen);
      int r0, d0, guard, n;
      mon_addr_q.delete();
      mon_data_q.delete();
      mon_cyc_q.delete();
      r0 = run_count;
      d0 = done_count;
      build_model();
      send_job();
      wait_run(r0);
      check("run_seen", run_count - r0, 1);
      repeat (bdelay) step();
      dut_busy = 1'b1;
      repeat (blen) step();
      dut_busy = 1'b0;
      guard = 0;
      while (done_count == d0 && guard < 100) begin
         step();
         guard++;
      end
      check("done_seen", done_count - d0, 1);
      check("done_after_fall", done_cyc, fall_cyc + 1);
      step();
      step();
      check("run_once", run_count - r0, 1);
      check("done_once", done_count - d0, 1);
      check("wr_num", mon_addr_q.size(), exp_addr_q.size());
      n = (mon_addr_q.size() < exp_addr_q.size()) ? mon_addr_q.size() : exp_addr_q.size();
      for (int i = 0; i < n; i++) begin
         check("wr_addr", mon_addr_q[i], exp_addr_q[i]);
         check("wr_data", mon_data_q[i], exp_data_q[i]);
      end
      if (mon_cyc_q.size() > 0) check("run_after_term", run_cyc, mon_cyc_q[mon_cyc_q.size() - 1] + 1);
      check("word_count", word_count, exp_cnt);
      check("err_end_word", err_end_word, exp_end);
      check("err_overflow", err_overflow, exp_ovf);
      check("err_timeout", err_timeout, 0);
      check("ready_idle", s_ready, 1);
      $display("[TB] job words=%0d writes=%0d count=%0d end_err=%0b ovf=%0b", job_q.size(),
               mon_addr_q.size(), word_count, err_end_word, err_overflow);
   endtask

   initial begin
      int r0, d0, guard;
      reset_b  = 1'b1;
      s_valid  = 1'b0;
      s_data   = '0;
      s_last   = 1'b0;
      dut_busy = 1'b0;
      repeat (3) step();
      reset_b = 1'b0;
      step();
      check("rst_s_ready", s_ready, 1);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_dut_run", dut_run, 0);
      check("rst_job_done", job_done, 0);
      check("rst_err_ovf", err_overflow, 0);
      check("rst_err_end", err_end_word, 0);
      check("rst_err_to", err_timeout, 0);
      check("rst_count", word_count, 0);

      // Basic 3-word job, busy rises 2 cycles after dut_run for 10 cycles.
      job_q = '{16'h0305, 16'hAAAA, 16'h5555};
      run_job(1, 10);

      // END_WORD in the middle is dropped but counted.
      job_q = '{16'h1111, EW, 16'h2222};
      run_job(0, 3);

      // Randomized jobs.
      for (int j = 0; j < 8; j++) begin
         int len = $urandom_range(20, 1);
         job_q.delete();
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(7) == 0) job_q.push_back(EW);
            else job_q.push_back(16'($urandom));
         end
         run_job($urandom_range(3), $urandom_range(6, 2));
      end

      // Address space exhausted: last address reserved for the terminator.
      job_q.delete();
      for (int k = 0; k < (1 << AW); k++) begin
         logic [15:0] w = 16'($urandom);
         if (w == EW) w = 16'h1234;
         job_q.push_back(w);
      end
      run_job(1, 2);

      // Reset while waiting for busy to fall, after an END_WORD error.
      job_q = '{16'h1234, EW, 16'h9999};
      r0 = run_count;
      send_job();
      wait_run(r0);
      step();
      dut_busy = 1'b1;
      repeat (3) step();
      check("pre_rst_err_end", err_end_word, 1);
      r0 = run_count;
      d0 = done_count;
      reset_b = 1'b1;
      step();
      dut_busy = 1'b0;
      step();
      reset_b = 1'b0;
      repeat (3) step();
      check("rst_mid_no_run", run_count - r0, 0);
      check("rst_mid_no_done", done_count - d0, 0);
      check("rst_mid_err_end", err_end_word, 0);
      check("rst_mid_ready", s_ready, 1);
      check("rst_mid_count", word_count, 0);
      $display("[TB] reset during WAIT_LO applied");
      job_q = '{16'h4321};
      run_job(2, 4);

`ifdef LOADER_TIMEOUT_EN
      // Busy never rises: watchdog ends the wait after TIMEOUT_CYCLES cycles.
      job_q = '{16'h0042, 16'h0043};
      r0 = run_count;
      d0 = done_count;
      send_job();
      wait_run(r0);
      check("to_run_seen", run_count - r0, 1);
      guard = 0;
      while (done_count == d0 && guard < 5000) begin
         step();
         guard++;
      end
      check("to_done_seen", done_count - d0, 1);
      check("to_done_delay", done_cyc - run_cyc, 4096);
      step();
      check("to_err_timeout", err_timeout, 1);
      $display("[TB] timeout job done after %0d cycles", done_cyc - run_cyc);
      job_q = '{16'h0777};
      run_job(0, 2);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/input_sram_loader.md
INPUT_SRAM_LOADER -- requirements
Module: input_sram_loader

Interface
REQ-001 SHALL provide parameter END_WORD, default 16'h00FF: terminator word appended after the last loaded word.
REQ-002 SHALL provide parameter ADDR_W, default 12: SRAM address width.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 4095: watchdog limit, used only with LOADER_TIMEOUT_EN.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports named as follows.
- clk  in  1  sole clock; all logic on the rising edge.
- reset_b  in  1  synchronous reset, active-high.
REQ-005 SHALL have the following host stream ports.
- s_valid  in  1  word available.
- s_ready  out  1  loader accepts the word.
- s_data  in  16  word to store.
- s_last  in  1  final word of the job.
REQ-006 SHALL have the following input-SRAM write ports.
- ldr_sram_write_address  out  12  write address.
- ldr_sram_write_data  out  16  write data.
- ldr_sram_write_enable  out  1  write strobe.
REQ-007 SHALL have the following DUT handshake ports.
- dut_run  out  1  one-cycle start pulse.
- dut_busy  in  1  DUT busy flag.
REQ-008 SHALL have the following status ports.
- job_done  out  1  one-cycle completion pulse.
- err_overflow  out  1  sticky: a word was dropped for lack of address space.
- err_end_word  out  1  sticky: a word equal to END_WORD was dropped.
- err_timeout  out  1  sticky: watchdog expired.
- word_count  out  12  words accepted in the current job.

Function
REQ-009 SHALL implement states IDLE, LOAD, TERM, RUN, WAIT_HI, WAIT_LO, DONE.
REQ-010 IDLE: s_ready=1; the first s_valid handshake is handled as in LOAD and moves to LOAD (or TERM if s_last).
REQ-011 LOAD: each s_valid&&s_ready writes s_data at the current address with write_enable high that same cycle, then increments the address and word_count.
REQ-012 Address SHALL start at 0 for every job and increment by 1; no wrap-around.
REQ-013 A handshaked word equal to END_WORD SHALL NOT be written; it sets err_end_word, consumes no address, and is still counted toward s_last.
REQ-014 When address reaches 2^ADDR_W-1, further words SHALL be accepted and dropped and SHALL set err_overflow; that final address is reserved for the terminator.
REQ-015 A handshake with s_last=1 SHALL move to TERM after processing that word.
REQ-016 TERM: s_ready=0; SHALL write END_WORD at the current address for exactly one cycle, then go to RUN.
REQ-017 RUN: dut_run=1 for exactly one cycle, then WAIT_HI.
REQ-018 WAIT_HI: wait for dut_busy=1, then WAIT_LO. WAIT_LO: wait for dut_busy=0, then DONE.
REQ-019 If dut_busy is already 1 in the RUN cycle, the next state SHALL still be WAIT_HI, which exits on the following cycle.
REQ-020 DONE: job_done=1 for one cycle, word_count holds its value, then IDLE.
REQ-021 Sticky errors SHALL clear only on reset or on the first handshake of the next job.
REQ-022 s_ready SHALL be 0 in TERM, RUN, WAIT_HI, WAIT_LO and DONE.
REQ-023 ldr_sram_write_enable SHALL never be high outside LOAD/IDLE handshakes and TERM.

Reset
REQ-024 Reset SHALL override every other event in the same cycle, including mid-job, and return to IDLE.
REQ-025 Reset values: all outputs 0 except s_ready=1; address=0; word_count=0; watchdog counter=0.
REQ-026 Reset SHALL NOT emit a terminator word or a dut_run pulse.

Configuration
REQ-027 SHALL use macro LOADER_TIMEOUT_EN.
- Defined: a watchdog counts cycles spent in WAIT_HI plus WAIT_LO. On reaching TIMEOUT_CYCLES it sets err_timeout and moves to DONE.
- Undefined: no watchdog logic; err_timeout is tied to 0; waits are unbounded.

Structure
REQ-028 Shared package ece564_pkg SHALL hold END_WORD, ADDR_W, DATA_W=16 and the loader state enum type.
REQ-029 The watchdog SHALL be a sub-module busy_watchdog (inputs: enable, clear; output: expired), instantiated only under LOADER_TIMEOUT_EN.

Verification
REQ-030 Bench SHALL cover the following directed scenarios.
- 3-word job 0x0305, 0xAAAA, 0x5555 (last) -> writes at addr 0,1,2, 0x00FF at addr 3; dut_run 1 cycle later; word_count=3.
- dut_busy high 2 cycles after dut_run for 10 cycles -> job_done exactly 1 cycle after busy falls.
- Middle word 0x00FF -> skipped, err_end_word=1, terminator at addr 2, word_count=3.
- 4096-word job -> addr 0..4094 written, word 4096 dropped, err_overflow=1, 0x00FF at addr 4095.
- reset_b asserted in WAIT_LO, then a new 1-word job -> write at addr 0, errors clear, no spurious dut_run.
- With LOADER_TIMEOUT_EN and dut_busy never rising -> err_timeout=1 and job_done after 4095 cycles in WAIT_HI.
